// File: rtl/seq_detector_param_if.sv
// -----------------------------------------------------------------------------
// seq_detector_param_if
// Bundles the configuration, serial-data and status signals of the programmable
// bit-pattern detector.
//   master : drives configuration / data / count_clr, observes status
//   slave  : the detector itself
// Parameters must match those of the attached seq_detector_param.
//   MAX_LEN : maximum pattern length (2..32)
//   CNT_W   : match counter width (1..32)
// -----------------------------------------------------------------------------
interface seq_detector_param_if #(
  parameter int MAX_LEN = 8,
  parameter int CNT_W   = 16
);
  localparam int LEN_W = $clog2(MAX_LEN + 1);

  logic               cfg_load;
  logic [MAX_LEN-1:0] cfg_pattern;
  logic [LEN_W-1:0]   cfg_len;
  logic               cfg_overlap;
  logic               enable;
  logic               data_valid;
  logic               data_in;
  logic               count_clr;
  logic               match;
  logic [CNT_W-1:0]   match_count;
  logic               cfg_err;
  logic               armed;

  modport master (
    output cfg_load, cfg_pattern, cfg_len, cfg_overlap,
    output enable, data_valid, data_in, count_clr,
    input  match, match_count, cfg_err, armed
  );

  modport slave (
    input  cfg_load, cfg_pattern, cfg_len, cfg_overlap,
    input  enable, data_valid, data_in, count_clr,
    output match, match_count, cfg_err, armed
  );
endinterface

// File: rtl/seq_detector_param.sv
// -----------------------------------------------------------------------------
// seq_detector_param
// Runtime-programmable serial bit-pattern detector. A cfg_load strobe latches
// pattern, length and overlap mode; qualified input bits shift into a history
// register and every completed pattern raises a one-cycle registered match
// pulse and bumps a saturating match counter.
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous active-low reset
//   bus   : seq_detector_param_if.slave (config, serial data, status)
// -----------------------------------------------------------------------------
module seq_detector_param #(
  parameter int MAX_LEN = 8,
  parameter int CNT_W   = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  seq_detector_param_if.slave  bus
);
  localparam int               LEN_W   = $clog2(MAX_LEN + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {S_UNCFG, S_RUN, S_ERR} state_t;

  state_t             state;
  logic [MAX_LEN-1:0] pat_q;     // pattern, already masked to len_q bits
  logic [MAX_LEN-1:0] mask_q;    // ones in the low len_q bits
  logic [MAX_LEN-1:0] hist;
  logic [LEN_W-1:0]   len_q;
  logic [LEN_W-1:0]   fill;      // valid history bits, capped at len_q
  logic               ovl_q;
  logic               match_q;
  logic               cfg_err_q;
  logic               armed_q;
  logic [CNT_W-1:0]   count_q;

  logic               cfg_legal;
  logic [MAX_LEN-1:0] cfg_mask;
  logic               accept;
  logic [MAX_LEN-1:0] hist_next;
  logic [LEN_W-1:0]   fill_inc;
  logic               hit;

  always_comb begin
    // NOTE: every combinational output gets a default before any conditional
    // logic, so no path leaves it unassigned and no latch is inferred.
    cfg_mask  = '0;
    cfg_legal = (bus.cfg_len >= LEN_W'(2)) && (bus.cfg_len <= LEN_W'(MAX_LEN));
    for (int i = 0; i < MAX_LEN; i++) begin
      cfg_mask[i] = (i < int'(bus.cfg_len));
    end

    // A bit coinciding with cfg_load belongs to neither configuration.
    accept    = (state == S_RUN) && bus.enable && bus.data_valid && !bus.cfg_load;
    hist_next = {hist[MAX_LEN-2:0], bus.data_in};
    fill_inc  = (fill == len_q) ? len_q : fill + LEN_W'(1);
    hit       = accept && (fill_inc == len_q) && ((hist_next & mask_q) == pat_q);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_UNCFG;
      pat_q     <= '0;
      mask_q    <= '0;
      hist      <= '0;
      len_q     <= '0;
      fill      <= '0;
      ovl_q     <= 1'b0;
      match_q   <= 1'b0;
      cfg_err_q <= 1'b0;
      armed_q   <= 1'b0;
      count_q   <= '0;
    end else if (bus.cfg_load) begin
      // NOTE: non-blocking assignments here so every register samples the
      // pre-edge values, independent of statement order.
      match_q <= 1'b0;
      count_q <= '0;
      if (cfg_legal) begin
        state     <= S_RUN;
        pat_q     <= bus.cfg_pattern & cfg_mask;
        mask_q    <= cfg_mask;
        len_q     <= bus.cfg_len;
        ovl_q     <= bus.cfg_overlap;
        hist      <= '0;
        fill      <= '0;
        cfg_err_q <= 1'b0;
        armed_q   <= 1'b1;
      end else begin
        state     <= S_ERR;
        cfg_err_q <= 1'b1;
        armed_q   <= 1'b0;
      end
    end else begin
      match_q <= hit;
      if (accept) begin
        hist <= hist_next;
        // Non-overlap mode forgets the history so the next match needs len fresh bits.
        fill <= (hit && !ovl_q) ? '0 : fill_inc;
      end
      // count_clr wins over a simultaneous match; the pulse itself still fires.
      if (bus.count_clr) begin
        count_q <= '0;
      end else if (hit && (count_q != CNT_MAX)) begin
        count_q <= count_q + CNT_W'(1);
      end
    end
  end

  assign bus.match       = match_q;
  assign bus.match_count = count_q;
  assign bus.cfg_err     = cfg_err_q;
  assign bus.armed       = armed_q;

endmodule

// File: doc/seq_detector_param.md
# seq_detector_param

Runtime-programmable serial bit-pattern detector. It is the parametrised successor of the fixed single-pattern detector. The pattern, its length (2..MAX_LEN) and the overlap mode are loaded through a configuration strobe. Input bits are qualified by a valid/enable pair. Each detection produces a registered one-cycle match pulse and increments a saturating match counter. The block sits on the serial data path and feeds control/status logic.

## Interface
- MAX_LEN, 8: maximum pattern length in bits; legal range 2..32.
- CNT_W, 16: match counter width; legal range 1..32.
- LEN_W, derived, $clog2(MAX_LEN+1): width of cfg_len.

- clk  in  1  single clock; all logic on rising edge.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- cfg_load  in  1  single-cycle strobe that loads the configuration and clears history and counter.
- cfg_pattern  in  MAX_LEN  pattern; bit [cfg_len-1] is the first bit received and bit [0] the last; bits at or above cfg_len are ignored.
- cfg_len  in  LEN_W  pattern length.
- cfg_overlap  in  1  1 = overlapping matches allowed; 0 = history restarts after each match.
- enable  in  1  detector enable; when 0, all input bits are ignored.
- data_valid  in  1  data_in is valid this cycle.
- data_in  in  1  serial data bit.
- count_clr  in  1  synchronous clear of match_count.
- match  out  1  registered one-cycle pulse per detection.
- match_count  out  CNT_W  saturating number of detections.
- cfg_err  out  1  last cfg_load carried an illegal length.
- armed  out  1  state is RUN.

## Operation
- FSM states:
  - UNCFG (reset state): no bits are accepted.
  - RUN: detection active.
  - ERR: no bits are accepted; cfg_err = 1.
- FSM transitions:
  - cfg_load with 2 <= cfg_len <= MAX_LEN, from any state -> RUN. Latch pattern, len and overlap; hist <= 0, fill <= 0, match_count <= 0, cfg_err <= 0.
  - cfg_load with an illegal cfg_len, from any state -> ERR. Set cfg_err <= 1 and match_count <= 0.
  - No other transitions occur. Only reset leaves ERR/RUN without a cfg_load.
- Accepted bit: state == RUN && enable && data_valid && !cfg_load.
  - A bit arriving in the same cycle as cfg_load is discarded.
- On an accepted bit:
  - hist <= {hist[MAX_LEN-2:0], data_in}.
  - fill <= min(fill+1, len).
- Match condition, evaluated on the updated values: fill_next == len && (hist_next & mask) == (pattern & mask), where mask = (1<<len)-1.
- After a match:
  - cfg_overlap = 1: fill stays at len, so the next bit can complete another match.
  - cfg_overlap = 0: fill <= 0, so a new match needs len fresh bits.
- Unaccepted cycles (enable = 0, data_valid = 0): hist and fill hold; match = 0.
- match_count update:
  - Increments on each match, saturating at 2^CNT_W-1.
  - count_clr has priority: in a cycle with both count_clr and a match, the count becomes 0 and that match is not counted. The match pulse still fires.

## Timing
- Reset values (reset = 0): state UNCFG, hist 0, fill 0, match 0, match_count 0, cfg_err 0, armed 0. Reset is asserted asynchronously and released synchronously to clk, with no glitch on outputs.
- match latency: match is high for exactly one cycle, in the cycle after the clock edge that samples the completing bit.
- match_count latency: match_count updates on the same edge that raises match.
- cfg_load latency: the configuration is effective from the next edge; the first bit can be accepted in the cycle after cfg_load.
- armed and cfg_err: registered, updating on the edge that samples cfg_load.
- Reset mid-stream: partial history is lost; after release the block is in UNCFG and a cfg_load is required.
- Back-to-back valid bits: one bit per cycle, no bubbles required.

## Test plan
- Overlap mode. MAX_LEN=8, cfg_len=4, cfg_pattern=8'h0B (1011), cfg_overlap=1; stream 1,0,1,1,0,1,1 with valid every cycle -> match after bits 4 and 7; match_count=2.
- Non-overlap mode. Same stream with cfg_overlap=0 -> a single match after bit 4; match_count=1.
- Gaps and enable. Pattern 101 (len 3); stream 1,0,1 with data_valid=0 for 3 cycles between each bit and enable=0 for a period during which a stray 1 is driven -> exactly one match, and the stray bit has no effect.
- Illegal configuration. cfg_len=1, then cfg_len=9 (MAX_LEN=8) -> cfg_err=1, armed=0, and a 1111 stream gives no match. A following legal cfg_load -> cfg_err=0, armed=1.
- Saturation and clear. CNT_W=2, pattern 11 with overlap, stream of 6 ones -> 5 matches; match_count stops at 3. Then count_clr together with a match -> count 0 and match pulse present.
- Reset mid-operation. Drive reset low after 3 bits of a 4-bit pattern -> all outputs go to reset values immediately. After release, bits without a cfg_load -> no match.
